// File: rtl/mux8_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux8_rr_arbiter
//
// Round-robin arbiter for one 8:1 mux-selected resource shared by 8
// requesters. Requester i maps to mux input i, so {sel2,sel1,sel0} = i.
// A grant is held until the owner drops its request. On release, the next
// owner is picked in the same cycle, so there is no idle bubble.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   An owner that has held the grant for HOLD_MAX cycles while another
//   requester waits is preempted. preempt pulses for one cycle when this
//   happens. When the macro is undefined, preempt is tied low and a grant
//   lasts until the owner releases it.
//
// Handshake: req[i] is a level. A requester keeps req[i] high until it
// sees gnt[i], and holds it for as long as it wants the resource. The grant
// ends at the first clock edge that samples req[i] low. Outputs change only
// on clock edges.
//
// Parameters:
//   HOLD_MAX     maximum hold cycles under contention (2..255), timeout only
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   req[7:0]     request per requester
//   gnt[7:0]     one-hot grant, zero when idle
//   sel0/1/2     mux select = granted index; holds the last index when idle
//   busy         high while a grant is active
//   preempt      one-cycle pulse on a timeout revocation
//   state_dbg_o  FSM state (0 = IDLE, 1 = GRANT)
// -----------------------------------------------------------------------------
module mux8_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       sel0,
  output logic       sel1,
  output logic       sel2,
  output logic       busy,
  output logic       preempt,
  output logic       state_dbg_o
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("mux8_rr_arbiter: HOLD_MAX must be in 2..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] last_q, last_d;
  logic       busy_q, busy_d;

  logic [7:0] req_others;
  logic [7:0] req_cand;
  logic [3:0] pick;
  logic       new_grant;

  // Returns {found, index} of the first set bit of r, scanning from last+1
  // and wrapping 7 -> 0. The loop runs from the lowest priority offset to
  // the highest, so the closest set bit is the one that remains.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int i = 8; i >= 1; i--) begin
      idx = last + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // While granted, last_q equals the owner index. Masking the owner means one
  // search covers both the release case (owner bit already low) and the
  // timeout case (owner still requesting but excluded).
  assign req_others = req & ~(8'b1 << sel_q);
  assign req_cand   = (state_q == GRANT) ? req_others : req;
  assign pick       = rr_pick(req_cand, last_q);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

  logic [7:0] hold_q, hold_d;
  logic       preempt_q, preempt_d;
  logic       hold_full;

  // hold_q counts completed hold cycles; the current cycle is the
  // HOLD_MAX-th once hold_q reaches HOLD_MAX-1.
  assign hold_full = (hold_q >= HOLD_MAX_C - 8'd1);
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    busy_d    = busy_q;
    new_grant = 1'b0;
`ifdef ARB_TIMEOUT_EN
    preempt_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pick[3]) new_grant = 1'b1;
      end
      GRANT: begin
        if (!req[sel_q]) begin
          if (pick[3]) begin
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = 8'h00;
            busy_d  = 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
        end else if (hold_full && pick[3]) begin
          new_grant = 1'b1;
          preempt_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
        busy_d  = 1'b0;
      end
    endcase

    if (new_grant) begin
      state_d = GRANT;
      gnt_d   = 8'b1 << pick[2:0];
      sel_d   = pick[2:0];
      last_d  = pick[2:0];
      busy_d  = 1'b1;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_comb begin
    hold_d = hold_q;
    if (new_grant || state_d == IDLE) begin
      hold_d = 8'h00;
    end else if (state_q == GRANT && hold_q < HOLD_MAX_C) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q    <= 8'h00;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 8'h00;
      sel_q   <= 3'd0;
      last_q  <= 3'd7;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt         = gnt_q;
  assign sel0        = sel_q[0];
  assign sel1        = sel_q[1];
  assign sel2        = sel_q[2];
  assign busy        = busy_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

  localparam int unsigned HOLD_MAX = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       sel0, sel1, sel2;
  logic       busy;
  logic       preempt;
  logic       state_dbg;

  mux8_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .gnt         (gnt),
    .sel0        (sel0),
    .sel1        (sel1),
    .sel2        (sel2),
    .busy        (busy),
    .preempt     (preempt),
    .state_dbg_o (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // vector table
  typedef struct {
    logic        rst;
    logic [7:0]  req;
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic        busy;
    logic        pre;
    logic [63:0] nm;
  } vec_t;

  vec_t vecs[$];

  // scoreboard: {gnt, sel, busy, preempt}
  logic [12:0] exp_q[$];
  logic [63:0] name_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic logic [12:0] observed();
    return {gnt, sel2, sel1, sel0, busy, preempt};
  endfunction

  task automatic add(input logic [7:0] r, input logic [7:0] g, input logic [2:0] s,
                     input logic b, input logic p, input logic [63:0] nm);
    vec_t v;
    v.rst = 1'b0; v.req = r; v.gnt = g; v.sel = s; v.busy = b; v.pre = p; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic add_rst();
    vec_t v;
    v.rst = 1'b1; v.req = 8'h00; v.gnt = 8'h00; v.sel = 3'd0; v.busy = 1'b0; v.pre = 1'b0;
    v.nm = "async_rs";
    vecs.push_back(v);
  endtask

  task automatic compare(input logic [12:0] act, input logic [12:0] exp, input logic [63:0] nm);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %0s: got gnt=%h sel=%0d busy=%b pre=%b, want gnt=%h sel=%0d busy=%b pre=%b",
               nm, act[12:5], act[4:2], act[1], act[0], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_front();
    logic [12:0] e;
    logic [63:0] n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      compare(observed(), e, n);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    @(negedge clk);
    check_front();
    req = v.req;
    exp_q.push_back({v.gnt, v.sel, v.busy, v.pre});
    name_q.push_back(v.nm);
  endtask

  task automatic flush();
    @(negedge clk);
    check_front();
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic async_reset(input logic [63:0] nm);
    flush();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    compare(observed(), 13'd0, nm);
    req = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [7:0] bit_of(input int i);
    return 8'(1) << i;
  endfunction

  initial begin
    reset_n = 1'b0;
    req     = 8'h00;

    // idle after reset
    for (int i = 0; i < 5; i++) add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "idle");

    // single one-cycle request
    add(8'h01, 8'h01, 3'd0, 1'b1, 1'b0, "single");
    add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "single_r");
    add_rst();

    // full rotation: each owner drops its bit for one cycle
    add(8'hFF, 8'h01, 3'd0, 1'b1, 1'b0, "rot_0");
    for (int k = 0; k < 8; k++) begin
      add(~bit_of(k), bit_of((k + 1) % 8), 3'((k + 1) % 8), 1'b1, 1'b0, "rot");
    end
    add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "rot_end");

    // owner 3 holds while 5 waits, then hands over on release
    add(8'h08, 8'h08, 3'd3, 1'b1, 1'b0, "own3");
    add(8'h28, 8'h08, 3'd3, 1'b1, 1'b0, "own3_hld");
    add(8'h28, 8'h08, 3'd3, 1'b1, 1'b0, "own3_hld");
    add(8'h20, 8'h20, 3'd5, 1'b1, 1'b0, "handover");
    add(8'h00, 8'h00, 3'd5, 1'b0, 1'b0, "idle_s5");

    // wrap priority: last owner 6
    add(8'h40, 8'h40, 3'd6, 1'b1, 1'b0, "own6");
    add(8'h00, 8'h00, 3'd6, 1'b0, 1'b0, "idle_s6");
    add(8'h41, 8'h01, 3'd0, 1'b1, 1'b0, "wrap");
    add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "idle_s0");
    add(8'h41, 8'h40, 3'd6, 1'b1, 1'b0, "rr_6");
    add(8'h00, 8'h00, 3'd6, 1'b0, 1'b0, "idle_s6");

    // release by k while k+1 newly requests
    add(8'h04, 8'h04, 3'd2, 1'b1, 1'b0, "own2");
    add(8'h0A, 8'h08, 3'd3, 1'b1, 1'b0, "k_plus1");
    add(8'h00, 8'h00, 3'd3, 1'b0, 1'b0, "idle_s3");
    add_rst();

    // contention with two requesters held high
    add(8'h03, 8'h01, 3'd0, 1'b1, 1'b0, "tmo");
    for (int c = 1; c < 10; c++) begin
      if (TMO) begin
        if (c < 4)       add(8'h03, 8'h01, 3'd0, 1'b1, 1'b0, "tmo");
        else if (c == 4) add(8'h03, 8'h02, 3'd1, 1'b1, 1'b1, "tmo_pre");
        else if (c < 8)  add(8'h03, 8'h02, 3'd1, 1'b1, 1'b0, "tmo");
        else if (c == 8) add(8'h03, 8'h01, 3'd0, 1'b1, 1'b1, "tmo_pre");
        else             add(8'h03, 8'h01, 3'd0, 1'b1, 1'b0, "tmo");
      end else begin
        add(8'h03, 8'h01, 3'd0, 1'b1, 1'b0, "no_tmo");
      end
    end
    add_rst();

    // lone owner past HOLD_MAX, then a second requester appears
    for (int c = 0; c < 6; c++) add(8'h01, 8'h01, 3'd0, 1'b1, 1'b0, "sat");
    if (TMO) begin
      add(8'h03, 8'h02, 3'd1, 1'b1, 1'b1, "sat_pre");
      add(8'h00, 8'h00, 3'd1, 1'b0, 1'b0, "sat_idle");
    end else begin
      add(8'h03, 8'h01, 3'd0, 1'b1, 1'b0, "sat_hold");
      add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "sat_idle");
    end

    // release from reset
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    compare(observed(), 13'd0, "reset");

    foreach (vecs[i]) begin
      if (vecs[i].rst) async_reset(vecs[i].nm);
      else             drive(vecs[i]);
    end
    flush();

    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: %0d results never checked, want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 mux-selected resource among 8 requesters.
- Drives the mux select lines and a one-hot grant vector, holding each grant until the owner releases its request.
- Sits beside the 8:1 mux in the lab datapath. Requester i maps to mux input i, so sel = {sel2, sel1, sel0} = i.

Parameters:
- HOLD_MAX, 16: maximum consecutive cycles one owner may hold the grant while others wait. Used only with ARB_TIMEOUT_EN. Legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  8  request per requester; bit i corresponds to mux input i.
- gnt  output  8  one-hot grant, or all zero when idle.
- sel0  output  1  mux select bit 0, which is the LSB of the granted index.
- sel1  output  1  mux select bit 1.
- sel2  output  1  mux select bit 2, the MSB.
- busy  output  1  high while any grant is active.
- preempt  output  1  one-cycle pulse when a grant is revoked by timeout. Tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (reset_n low, takes effect asynchronously, including mid-grant):
  - gnt=0, {sel2,sel1,sel0}=0, busy=0, preempt=0.
  - Internal last-owner pointer = 7, so requester 0 has first priority.
  - State = IDLE; hold counter = 0.
- All outputs are registered. gnt is always one-hot or zero. sel always equals the index of the set gnt bit while busy=1.
- Winner search:
  - Scan req starting at (last+1) mod 8 and wrap 7→0. The first set bit wins.
  - The pointer updates to the winner index when the grant is issued.
- State IDLE:
  - If req != 0, the winner is granted at the next rising edge. State goes to GRANT, busy=1, gnt[w]=1, sel=w.
  - Latency from req to gnt is 1 cycle.
  - If req == 0, remain in IDLE. sel keeps the last granted index (mux output stays stable), gnt=0, busy=0.
- State GRANT, owner k:
  - While req[k]=1: hold gnt/sel unchanged. New requests from others do not disturb the grant.
  - When req[k]=0 is sampled, handover happens with no bubble:
    - If any other req bit is set, the round-robin winner (search starting at k+1) is granted at that same edge.
    - Otherwise go to IDLE: gnt=0, busy=0 at that edge.
  - If req[k] drops and re-rises in the same sampled cycle, only the sampled value counts.
- Simultaneous events:
  - Release by k while k+1 newly requests: k+1 wins.
  - All 8 requesting continuously and each releasing after one grant: grants rotate 0,1,...,7,0.
- Fairness: no requester waits more than 7 grants while continuously requesting.
- X on req is not handled; the bench must drive known values.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each GRANT cycle.
  - When the owner has held for HOLD_MAX cycles and at least one other req bit is set, the grant moves to the round-robin winner (excluding the owner) at the next edge. preempt pulses high for that cycle.
  - If no other requester is waiting, the owner keeps the grant and the counter saturates at HOLD_MAX. Preemption then occurs on the first edge where another request is sampled.
  - A preempted owner still holding req re-competes normally.
- Undefined: no counter is built, preempt is tied 0, and the grant is held until release indefinitely.

Test Plan:
- Reset, then req=8'h00 for 5 cycles → gnt=0, busy=0, sel=3'b000. Assert reset_n=0 mid-grant → gnt=0 immediately (asynchronous, no clock edge needed).
- req=8'h01 for 1 cycle then 0 → gnt=8'h01 and sel=0 on the next edge. Following edge: gnt=0, busy=0, sel stays 0.
- req=8'hFF, with each owner dropping its bit for 1 cycle after receiving its grant → gnt rotates 01,02,04,...,80,01 with no idle cycle between grants, and {sel2,sel1,sel0} counts 0..7.
- Owner 3 holds (req=8'h08), then req becomes 8'h28 → gnt remains 8'h08. Drop bit 3 → gnt=8'h20 and sel=5 the same edge bit 3 is sampled low.
- Last owner 6, then req=8'h41 → bit 0 wins (wrap from 7). After release, req=8'h41 again → bit 6 wins.
- With ARB_TIMEOUT_EN and HOLD_MAX=4: req=8'h03 held high → gnt=01 for 4 cycles, then 02 with preempt=1 for one cycle, then 01 again after 4 more cycles. Without the macro, gnt stays 01 and preempt stays 0.
